// File: rtl/adder_share_arbiter.sv
// ---------------------------------------------------------------------------
// adder_share_arbiter
//   Time-shares one W-bit adder (Adder_* valid/ack callee) among NREQ
//   requesters. Round-robin grant, one transaction in flight, return-to-zero
//   handshake toward the adder, and a watchdog that aborts a transaction when
//   the adder never acks.
//
// Ports
//   CLK, RSTn                 clock (posedge), synchronous active-low reset
//   req_valid[NREQ]           per-requester request, held until its req_ack
//   req_datain1/2[NREQ*W]     operands, requester i at [i*W +: W]
//   req_ack[NREQ]             one-cycle one-hot completion pulse
//   req_dataout/carryout/exc  adder result, valid with req_ack, held otherwise
//   req_timeout               set with req_ack when the watchdog aborted
//   grant_idx                 current/last granted requester
//   Adder_datain1/2, Adder_valid   request side toward the adder
//   Adder_dataout/carryout/Exc, Adder_ack   response side from the adder
// ---------------------------------------------------------------------------
module adder_share_arbiter #(
    parameter int NREQ    = 2,
    parameter int W       = 24,
    parameter int TIMEOUT = 64,
    localparam int GW     = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW     = $clog2(TIMEOUT)
) (
    input  logic                CLK,
    input  logic                RSTn,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*W-1:0]   req_datain1,
    input  logic [NREQ*W-1:0]   req_datain2,
    output logic [NREQ-1:0]     req_ack,
    output logic [W-1:0]        req_dataout,
    output logic                req_carryout,
    output logic [1:0]          req_exc,
    output logic                req_timeout,
    output logic [GW-1:0]       grant_idx,
    output logic [W-1:0]        Adder_datain1,
    output logic [W-1:0]        Adder_datain2,
    output logic                Adder_valid,
    input  logic [1:0]          Adder_Exc,
    input  logic [W-1:0]        Adder_dataout,
    input  logic                Adder_carryout,
    input  logic                Adder_ack
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   rr_q, rr_d;
    logic [CW-1:0]   wd_q, wd_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [W-1:0]    a1_q, a1_d, a2_q, a2_d;
    logic            avalid_q, avalid_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [W-1:0]    dout_q, dout_d;
    logic            carry_q, carry_d;
    logic [1:0]      exc_q, exc_d;
    logic            tout_q, tout_d;

    // Round-robin pick: first set request at or after rr_q, wrapping.
    logic [GW-1:0]   pick;
    logic            found;
    logic [GW-1:0]   rr_next;

    always_comb begin
        int idx;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 0; off < NREQ; off++) begin
            idx = int'(rr_q) + off;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req_valid[GW'(idx)]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end
    end

    assign rr_next = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        wd_d     = wd_q;
        grant_d  = grant_q;
        a1_d     = a1_q;
        a2_d     = a2_q;
        avalid_d = avalid_q;
        ack_d    = '0;           // completion is a single-cycle pulse
        dout_d   = dout_q;
        carry_d  = carry_q;
        exc_d    = exc_q;
        tout_d   = tout_q;

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d  = pick;
                    a1_d     = req_datain1[pick*W +: W];
                    a2_d     = req_datain2[pick*W +: W];
                    avalid_d = 1'b1;
                    wd_d     = '0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                // A real ack takes precedence over a coincident watchdog expiry.
                if (Adder_ack) begin
                    dout_d         = Adder_dataout;
                    carry_d        = Adder_carryout;
                    exc_d          = Adder_Exc;
                    tout_d         = 1'b0;
                    ack_d[grant_q] = 1'b1;
                    avalid_d       = 1'b0;
                    rr_d           = rr_next;
                    state_d        = RELEASE;
                end else if (wd_q == CW'(TIMEOUT - 1)) begin
                    dout_d         = '0;
                    carry_d        = 1'b0;
                    exc_d          = '0;
                    tout_d         = 1'b1;
                    ack_d[grant_q] = 1'b1;
                    avalid_d       = 1'b0;
                    rr_d           = rr_next;
                    state_d        = RELEASE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            RELEASE: begin
                // Wait out the return-to-zero half of the handshake; a late
                // ack after a watchdog abort is swallowed here.
                if (!Adder_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q  <= IDLE;
            rr_q     <= '0;
            wd_q     <= '0;
            grant_q  <= '0;
            a1_q     <= '0;
            a2_q     <= '0;
            avalid_q <= 1'b0;
            ack_q    <= '0;
            dout_q   <= '0;
            carry_q  <= 1'b0;
            exc_q    <= '0;
            tout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            wd_q     <= wd_d;
            grant_q  <= grant_d;
            a1_q     <= a1_d;
            a2_q     <= a2_d;
            avalid_q <= avalid_d;
            ack_q    <= ack_d;
            dout_q   <= dout_d;
            carry_q  <= carry_d;
            exc_q    <= exc_d;
            tout_q   <= tout_d;
        end
    end

    assign req_ack       = ack_q;
    assign req_dataout   = dout_q;
    assign req_carryout  = carry_q;
    assign req_exc       = exc_q;
    assign req_timeout   = tout_q;
    assign grant_idx     = grant_q;
    assign Adder_datain1 = a1_q;
    assign Adder_datain2 = a2_q;
    assign Adder_valid   = avalid_q;

endmodule
